// File: rtl/data_bus_adapter.sv
// Core data-bus to single-outstanding req/ack memory adapter with byte lanes, load alignment and timeout.
// Optional macro MISALIGNED_TRAP_EN: reject misaligned half/word accesses instead of truncating the offset.
module data_bus_adapter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_READ_VALUE = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [1:0]  core_option,
  input  logic        core_unsigned,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  output logic [31:0] core_read_data,
  output logic        core_stall,
  output logic        core_err,
  output logic        mem_cyc,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic        request;
  logic        reject;
  logic [1:0]  size_p0;
  logic [1:0]  off_p0;
  logic        we_p1;
  logic        uns_p1;
  logic [1:0]  size_p1;
  logic [1:0]  off_p1;
  logic [31:0] tmo_cnt;
  logic        timeout_hit;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_sel = 4'b0001 << off;
      SZ_HALF: lane_sel = off[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: lane_wdata = {4{d[7:0]}};
      SZ_HALF: lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic        [31:0] shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = rdata >> {off, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (size)
      SZ_BYTE: load_align = uns ? {24'd0, shifted[7:0]}  : 32'(b);
      SZ_HALF: load_align = uns ? {16'd0, shifted[15:0]} : 32'(h);
      default: load_align = shifted;
    endcase
  endfunction

  assign request     = core_read | core_write;
  assign size_p0     = (core_option == SZ_BYTE || core_option == SZ_HALF) ? core_option : SZ_WORD;
  assign timeout_hit = (TMO_LIMIT != 32'd0) && (tmo_cnt == TMO_LIMIT - 32'd1);

  // Natural-alignment truncation; only matters when misaligned accesses are not trapped.
  always_comb begin
    case (size_p0)
      SZ_BYTE: off_p0 = core_address[1:0];
      SZ_HALF: off_p0 = {core_address[1], 1'b0};
      default: off_p0 = 2'b00;
    endcase
  end

`ifdef MISALIGNED_TRAP_EN
  assign reject = ((size_p0 == SZ_HALF) && core_address[0]) ||
                  ((size_p0 == SZ_WORD) && (core_address[1:0] != 2'b00));
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    core_stall = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          core_stall = 1'b1;
          state_next = reject ? DONE : REQ;
        end
      end
      REQ: begin
        core_stall = 1'b1;
        if (mem_ack || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch (IDLE) -> bus cycle and completion (REQ)
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cyc        <= 1'b0;
      mem_we         <= 1'b0;
      mem_sel        <= 4'd0;
      mem_addr       <= 32'd0;
      mem_wdata      <= 32'd0;
      core_read_data <= 32'd0;
      core_err       <= 1'b0;
      tmo_cnt        <= 32'd0;
      we_p1          <= 1'b0;
      uns_p1         <= 1'b0;
      size_p1        <= SZ_BYTE;
      off_p1         <= 2'b00;
    end else begin
      core_err <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            if (reject) begin
              core_err <= 1'b1;
              if (!core_write) core_read_data <= ERR_READ_VALUE;
            end else begin
              mem_cyc   <= 1'b1;
              mem_we    <= core_write;
              mem_sel   <= lane_sel(size_p0, off_p0);
              mem_addr  <= {core_address[31:2], 2'b00};
              mem_wdata <= lane_wdata(size_p0, core_write_data);
              we_p1     <= core_write;
              uns_p1    <= core_unsigned;
              size_p1   <= size_p0;
              off_p1    <= off_p0;
              tmo_cnt   <= 32'd0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_cyc <= 1'b0;
            if (!we_p1) core_read_data <= load_align(mem_rdata, off_p1, size_p1, uns_p1);
          end else if (timeout_hit) begin
            mem_cyc  <= 1'b0;
            core_err <= 1'b1;
            if (!we_p1) core_read_data <= ERR_READ_VALUE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_adapter.sv
// Scoreboard bench for data_bus_adapter: expected transactions queued at drive time, checked at completion.
module tb_data_bus_adapter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_read, core_write, core_unsigned;
  logic [1:0]  core_option;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic        core_stall, core_err;
  logic        mem_cyc, mem_we, mem_ack;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  data_bus_adapter #(.TIMEOUT_CYCLES(TMO), .ERR_READ_VALUE(32'hFFFFFFFF)) dut (
    .clk(clk), .reset(reset),
    .core_read(core_read), .core_write(core_write), .core_option(core_option),
    .core_unsigned(core_unsigned), .core_address(core_address),
    .core_write_data(core_write_data), .core_read_data(core_read_data),
    .core_stall(core_stall), .core_err(core_err),
    .mem_cyc(mem_cyc), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int stalls, input int reqs);
    exp_t e;
    e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.err = err; e.stalls = stalls; e.reqs = reqs;
    return e;
  endfunction

  // Reference for naturally aligned accesses with zero-wait ack.
  function automatic exp_t model(input logic we, input logic [1:0] opt, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd);
    exp_t e;
    logic [7:0]  by;
    logic [15:0] hw;
    int off;
    off = int'(addr[1:0]);
    e = mk(we, 4'b1111, {addr[31:2], 2'b00}, wd, mrd, 1'b0, 2, 1);
    if (opt == 2'b00) begin
      e.sel = 4'b0001 << off;
      e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      by = mrd[8*off +: 8];
      e.rdata = uns ? {24'd0, by} : {{24{by[7]}}, by};
    end else if (opt == 2'b01) begin
      e.sel = (off >= 2) ? 4'b1100 : 4'b0011;
      e.wdata = {wd[15:0], wd[15:0]};
      hw = mrd[8*off +: 16];
      e.rdata = uns ? {16'd0, hw} : {{16{hw[15]}}, hw};
    end
    return e;
  endfunction

  // Called just after a negedge; returns just after a negedge in IDLE.
  task automatic run_access(input logic we, input logic [1:0] opt, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                            input int ack_wait, input exp_t e);
    exp_t x;
    int stalls, reqs;
    bit done;
    sb.push_back(e);
    core_write = we; core_read = !we; core_option = opt; core_unsigned = uns;
    core_address = addr; core_write_data = wd;
    stalls = 0; reqs = 0; done = 0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!core_stall) begin
        done = 1;
      end else begin
        stalls++;
        if (mem_cyc) begin
          chk("mem_sel",   {28'd0, mem_sel}, {28'd0, sb[0].sel});
          chk("mem_addr",  mem_addr, sb[0].addr);
          chk("mem_wdata", mem_wdata, sb[0].wdata);
          chk("mem_we",    {31'd0, mem_we}, {31'd0, sb[0].we});
          mem_ack = (reqs == ack_wait);
          mem_rdata = mrd;
          reqs++;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
      end
    end
    if (!done) chk("done_bound", 32'd0, 32'd1);
    x = sb.pop_front();
    chk("stall_cycles", 32'(stalls), 32'(x.stalls));
    chk("req_cycles",   32'(reqs),   32'(x.reqs));
    chk("core_err",     {31'd0, core_err}, {31'd0, x.err});
    chk("cyc_done",     {31'd0, mem_cyc}, 32'd0);
    if (!x.we) chk("read_data", core_read_data, x.rdata);
    core_read = 1'b0; core_write = 1'b0;
    @(negedge clk); #1;
    chk("err_pulse", {31'd0, core_err}, 32'd0);
    chk("idle_stall", {31'd0, core_stall}, 32'd0);
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [1:0]  r_opt;
    logic [31:0] r_addr, r_wd, r_mrd;

    reset = 1'b1; core_read = 1'b0; core_write = 1'b0; core_option = 2'b00;
    core_unsigned = 1'b0; core_address = 32'd0; core_write_data = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_cyc",   {31'd0, mem_cyc}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_sel",   {28'd0, mem_sel}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", core_read_data, 32'd0);
    chk("rst_err",   {31'd0, core_err}, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);

    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'd0, 0,
               mk(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1));
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80AABBCC, 0,
               mk(1'b0, 4'b1000, 32'h100, 32'd0, 32'hFFFFFF80, 1'b0, 2, 1));
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80AABBCC, 0,
               mk(1'b0, 4'b1000, 32'h100, 32'd0, 32'h00000080, 1'b0, 2, 1));
    run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 32'd0, 0,
               mk(1'b1, 4'b1100, 32'h20, 32'h12341234, 32'd0, 1'b0, 2, 1));
    run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h13579BDF, 5,
               mk(1'b0, 4'b1111, 32'h40, 32'd0, 32'h13579BDF, 1'b0, 7, 6));
    run_access(1'b0, 2'b10, 1'b0, 32'h50, 32'd0, 32'h0, -1,
               mk(1'b0, 4'b1111, 32'h50, 32'd0, 32'hFFFFFFFF, 1'b1, TMO + 1, TMO));
    run_access(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'h80017FFF, 0,
               mk(1'b0, 4'b1100, 32'h10, 32'd0, 32'hFFFF8001, 1'b0, 2, 1));
    run_access(1'b0, 2'b11, 1'b0, 32'h60, 32'd0, 32'hA5A50001, TMO - 1,
               mk(1'b0, 4'b1111, 32'h60, 32'd0, 32'hA5A50001, 1'b0, TMO + 1, TMO));
`ifdef MISALIGNED_TRAP_EN
    run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 32'h11223344, 0,
               mk(1'b0, 4'b1111, 32'h100, 32'd0, 32'hFFFFFFFF, 1'b1, 1, 0));
`else
    run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 32'h11223344, 0,
               mk(1'b0, 4'b1111, 32'h100, 32'd0, 32'h11223344, 1'b0, 2, 1));
`endif

    for (int k = 0; k < 10; k++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_opt = 2'($urandom_range(0, 2));
      r_uns = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if (r_opt == 2'b01) r_addr[0] = 1'b0;
      if (r_opt == 2'b10) r_addr[1:0] = 2'b00;
      r_wd = $urandom;
      r_mrd = $urandom;
      run_access(r_we, r_opt, r_uns, r_addr, r_wd, r_mrd, 0,
                 model(r_we, r_opt, r_uns, r_addr, r_wd, r_mrd));
    end

    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_ack_cyc",   {31'd0, mem_cyc}, 32'd0);
    chk("stray_ack_stall", {31'd0, core_stall}, 32'd0);
    chk("stray_ack_err",   {31'd0, core_err}, 32'd0);
    mem_ack = 1'b0;

    core_read = 1'b1; core_option = 2'b10; core_address = 32'h200;
    @(negedge clk); #1;
    chk("pre_rst_cyc", {31'd0, mem_cyc}, 32'd1);
    reset = 1'b1; core_read = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_cyc",   {31'd0, mem_cyc}, 32'd0);
    chk("mid_rst_err",   {31'd0, core_err}, 32'd0);
    chk("mid_rst_stall", {31'd0, core_stall}, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_err",  {31'd0, core_err}, 32'd0);
    run_access(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A7, 32'd0, 1,
               mk(1'b1, 4'b0010, 32'h300, 32'hA7A7A7A7, 32'd0, 1'b0, 3, 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
